// File: rtl/core_control_unit_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: FSM states,
// decode_unit control-field values and trap causes.
package core_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_RES  = 2'd1;
  localparam logic [1:0] WB_ADDR = 2'd2;

  localparam logic [1:0] JMP_NONE   = 2'd0;
  localparam logic [1:0] JMP_UNCOND = 2'd1;
  localparam logic [1:0] JMP_COND   = 2'd2;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [1:0] TRAP_NONE        = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL     = 2'd1;
  localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'd2;

  function automatic logic take_jump(input logic [1:0] jmp_op, input logic br_taken);
    return (jmp_op == JMP_UNCOND) || ((jmp_op == JMP_COND) && br_taken);
  endfunction

endpackage

// File: rtl/core_control_unit_mem_wait_timer.sv
// Counts stalled memory-request cycles and flags when the wait limit is reached.
// A MEM_TIMEOUT of 0 never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a held count cannot wrap back below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/core_control_unit.sv
// Multi-cycle sequencer for the RV32I core: fetch/decode/exec/mem/wb control,
// shared memory-port arbitration, retire counting and sticky traps.
module core_control_unit
  import core_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             dec_fault,
  input  logic [1:0]       dec_wb_op,
  input  logic [1:0]       dec_jmp_op,
  input  logic [1:0]       dec_mem_op,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired
);

  state_t state;
  logic   wait_clear;
  logic   wait_en;
  logic   wait_expired;

  // The counter is held at zero outside the memory states, so it is always
  // fresh on entry to FETCH or MEM.
  assign wait_clear = (state != ST_FETCH) && (state != ST_MEM);
  assign wait_en    = mem_req && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clear),
    .enable (wait_en),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr_sel <= 1'b0;
      rf_we        <= 1'b0;
      pc_we        <= 1'b0;
      halted       <= 1'b0;
      trap_cause   <= TRAP_NONE;
      retired      <= '0;
    end else begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr_sel <= 1'b0;
      rf_we        <= 1'b0;
      pc_we        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (wait_expired) begin
            state      <= ST_TRAP;
            halted     <= 1'b1;
            trap_cause <= TRAP_MEM_TIMEOUT;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_fault) begin
            state      <= ST_TRAP;
            halted     <= 1'b1;
            trap_cause <= TRAP_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dec_mem_op != MEM_NONE) begin
            state        <= ST_MEM;
            mem_req      <= 1'b1;
            mem_addr_sel <= 1'b1;
            mem_we       <= (dec_mem_op == MEM_STORE);
          end else begin
            state <= ST_WB;
            rf_we <= (dec_wb_op != WB_NONE);
            pc_we <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            state <= ST_WB;
            rf_we <= (dec_wb_op != WB_NONE);
            pc_we <= 1'b1;
          end else if (wait_expired) begin
            state      <= ST_TRAP;
            halted     <= 1'b1;
            trap_cause <= TRAP_MEM_TIMEOUT;
          end else begin
            mem_req      <= 1'b1;
            mem_addr_sel <= 1'b1;
            mem_we       <= mem_we;
          end
        end
        ST_WB: begin
          retired <= retired + RET_W'(1);
          if (run) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture strobes complete in the same cycle as the memory handshake.
  assign ir_we  = (state == ST_FETCH) && mem_ready;
  assign mdr_we = (state == ST_MEM) && mem_ready && (dec_mem_op == MEM_LOAD);

  // Branch outcome is only valid during WB, so these stay combinational.
  assign wb_sel = (state == ST_WB) ? dec_wb_op : WB_NONE;
  assign pc_sel = (state == ST_WB) && take_jump(dec_jmp_op, br_taken);

endmodule

// File: tb/tb_core_control_unit.sv
// Scoreboard bench for core_control_unit: per-scenario tasks push expected
// write-back results and compare them when the DUT reaches WB.
module tb_core_control_unit;

  localparam int TMO   = 4;
  localparam int RET_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             dec_fault;
  logic [1:0]       dec_wb_op;
  logic [1:0]       dec_jmp_op;
  logic [1:0]       dec_mem_op;
  logic             br_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             mdr_we;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             pc_we;
  logic             pc_sel;
  logic             halted;
  logic [1:0]       trap_cause;
  logic [RET_W-1:0] retired;

  typedef struct {
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_sel;
  } wb_exp_t;

  wb_exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  always #5 clk = ~clk;

  core_control_unit #(
    .MEM_TIMEOUT(TMO),
    .RET_W      (RET_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .dec_fault   (dec_fault),
    .dec_wb_op   (dec_wb_op),
    .dec_jmp_op  (dec_jmp_op),
    .dec_mem_op  (dec_mem_op),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_we       (ir_we),
    .mdr_we      (mdr_we),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .halted      (halted),
    .trap_cause  (trap_cause),
    .retired     (retired)
  );

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, rf_we, pc_we, halted, trap_cause} !== 6'b0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_async: req=%0b rf=%0b pc=%0b halted=%0b cause=%0d retired=%0d, required all 0",
               mem_req, rf_we, pc_we, halted, trap_cause, retired);
    end
    exp_retired = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    run = 1'b0; mem_ready = 1'b1; dec_fault = 1'b0;
    dec_wb_op = 2'd0; dec_jmp_op = 2'd0; dec_mem_op = 2'd0; br_taken = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, ir_we, mdr_we, rf_we, pc_we, halted, trap_cause} !== 9'b0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%0b we=%0b ir=%0b halted=%0b cause=%0d retired=%0d, required all 0",
               mem_req, mem_we, ir_we, halted, trap_cause, retired);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || ir_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_no_run: %0d cycles with mem_req/ir_we set, required 0", bad);
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [1:0] wb, input logic [1:0] jmp,
                           input logic [1:0] mop, input logic taken, input int fwait, input int mwait);
    wb_exp_t e;
    int cyc, fcyc, mcyc, irc, mdrc, wec, wb_cyc, exp_wb;
    bit done;
    e.rf_we  = (wb != 2'd0);
    e.wb_sel = wb;
    e.pc_sel = (jmp == 2'd1) || ((jmp == 2'd2) && taken);
    sb.push_back(e);
    @(negedge clk);
    dec_fault = 1'b0; dec_wb_op = wb; dec_jmp_op = jmp; dec_mem_op = mop; br_taken = taken;
    run = 1'b1;
    cyc = 0; fcyc = 0; mcyc = 0; irc = 0; mdrc = 0; wec = 0; wb_cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      if (mem_req && !mem_addr_sel) begin
        run = 1'b0;
        fcyc++;
        mem_ready = (fcyc > fwait);
      end else if (mem_req && mem_addr_sel) begin
        mcyc++;
        mem_ready = (mcyc > mwait);
        if (mem_we !== (mop == 2'd2)) wec++;
      end
      #1;
      if (ir_we) irc++;
      if (mdr_we) mdrc++;
      if (pc_we) begin
        done = 1;
        wb_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_sb_empty: WB seen with no expectation queued", name);
        end else begin
          e = sb.pop_front();
          if (rf_we !== e.rf_we || wb_sel !== e.wb_sel || pc_sel !== e.pc_sel) begin
            errors++;
            $display("FAIL %s_wb: rf_we=%0b wb_sel=%0d pc_sel=%0b, required %0b %0d %0b",
                     name, rf_we, wb_sel, pc_sel, e.rf_we, e.wb_sel, e.pc_sel);
          end
        end
      end
    end
    mem_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no pc_we within 40 cycles, required one", name);
    end
    exp_wb = (fwait + 1) + 2 + ((mop != 2'd0) ? (mwait + 1) : 0) + 1;
    checks++;
    if (wb_cyc != exp_wb) begin
      errors++;
      $display("FAIL %s_latency: WB at cycle %0d, required %0d", name, wb_cyc, exp_wb);
    end
    checks++;
    if (irc != 1 || fcyc != fwait + 1) begin
      errors++;
      $display("FAIL %s_fetch: ir_we pulses %0d fetch cycles %0d, required 1 and %0d",
               name, irc, fcyc, fwait + 1);
    end
    checks++;
    if (mcyc != ((mop != 2'd0) ? mwait + 1 : 0) || wec != 0 || mdrc != ((mop == 2'd1) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_mem: mem cycles %0d bad mem_we %0d mdr pulses %0d, required %0d 0 %0d",
               name, mcyc, wec, mdrc, (mop != 2'd0) ? mwait + 1 : 0, (mop == 2'd1) ? 1 : 0);
    end
    exp_retired++;
    @(negedge clk);
    checks++;
    if (retired !== RET_W'(exp_retired) || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_retire: retired=%0d mem_req=%0b, required %0d 0", name, retired, mem_req, exp_retired);
    end
  endtask

  task automatic test_alu();
    run_instr("addi", 2'd1, 2'd0, 2'd0, 1'b0, 0, 0);
    run_instr("auipc", 2'd2, 2'd0, 2'd0, 1'b0, 2, 0);
  endtask

  task automatic test_load_store();
    run_instr("lw", 2'd1, 2'd0, 2'd1, 1'b0, 0, 3);
    run_instr("sw", 2'd0, 2'd0, 2'd2, 1'b0, 1, 0);
    run_instr("lw_edge", 2'd1, 2'd0, 2'd1, 1'b0, TMO, TMO);
  endtask

  task automatic test_branch();
    run_instr("bne_t", 2'd0, 2'd2, 2'd0, 1'b1, 0, 0);
    run_instr("bne_nt", 2'd0, 2'd2, 2'd0, 1'b0, 0, 0);
    run_instr("jal", 2'd1, 2'd1, 2'd0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    wb_exp_t e;
    int wbs[2];
    int npc, cyc;
    e.rf_we = 1'b1; e.wb_sel = 2'd1; e.pc_sel = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    dec_fault = 1'b0; dec_wb_op = 2'd1; dec_jmp_op = 2'd0; dec_mem_op = 2'd0; br_taken = 1'b0;
    run = 1'b1; mem_ready = 1'b1;
    npc = 0; cyc = 0; wbs[0] = 0; wbs[1] = 0;
    while (npc < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (npc == 1 && mem_req) run = 1'b0;
      #1;
      if (pc_we) begin
        wbs[npc] = cyc;
        npc++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb_empty: WB seen with no expectation queued");
        end else begin
          e = sb.pop_front();
          if (rf_we !== e.rf_we || wb_sel !== e.wb_sel || pc_sel !== e.pc_sel) begin
            errors++;
            $display("FAIL b2b_wb: rf_we=%0b wb_sel=%0d pc_sel=%0b, required %0b %0d %0b",
                     rf_we, wb_sel, pc_sel, e.rf_we, e.wb_sel, e.pc_sel);
          end
        end
      end
    end
    mem_ready = 1'b0;
    run = 1'b0;
    exp_retired += 2;
    checks++;
    if (wbs[0] != 4 || wbs[1] != 8) begin
      errors++;
      $display("FAIL b2b_timing: WB cycles %0d and %0d, required 4 and 8", wbs[0], wbs[1]);
    end
    @(negedge clk);
    checks++;
    if (retired !== RET_W'(exp_retired)) begin
      errors++;
      $display("FAIL b2b_retire: retired=%0d, required %0d", retired, exp_retired);
    end
  endtask

  task automatic test_illegal();
    int cyc, bad;
    @(negedge clk);
    dec_fault = 1'b1; dec_wb_op = 2'd1; dec_jmp_op = 2'd1; dec_mem_op = 2'd0;
    run = 1'b1; mem_ready = 1'b1;
    cyc = 0;
    while (!halted && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (halted !== 1'b1 || trap_cause !== 2'd1 || cyc != 3) begin
      errors++;
      $display("FAIL illegal_trap: halted=%0b cause=%0d after %0d cycles, required 1 1 3",
               halted, trap_cause, cyc);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({mem_req, mem_we, ir_we, mdr_we, rf_we, pc_we, pc_sel} !== 7'b0 ||
          halted !== 1'b1 || trap_cause !== 2'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL illegal_sticky: %0d cycles with strobes or trap state wrong, required 0", bad);
    end
    run = 1'b0; mem_ready = 1'b0; dec_fault = 1'b0;
    pulse_reset();
  endtask

  task automatic test_timeout();
    int cyc, nreq;
    @(negedge clk);
    dec_fault = 1'b0; run = 1'b1; mem_ready = 1'b0;
    cyc = 0; nreq = 0;
    while (!halted && cyc < 20) begin
      @(negedge clk);
      cyc++;
      run = 1'b0;
      if (mem_req) nreq++;
    end
    checks++;
    if (halted !== 1'b1 || trap_cause !== 2'd2 || nreq != TMO + 1) begin
      errors++;
      $display("FAIL mem_timeout: halted=%0b cause=%0d req cycles %0d, required 1 2 %0d",
               halted, trap_cause, nreq, TMO + 1);
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_fetch();
    int bad;
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_fetch_req: mem_req=%0b, required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_fetch_drop: mem_req=%0b right after rst_n fall, required 0", mem_req);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ir_we !== 1'b0 || mem_req !== 1'b0 || retired !== '0) bad++;
    end
    mem_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stray_ready: %0d cycles reacting to mem_ready after reset, required 0", bad);
    end
    exp_retired = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_illegal();
    run_instr("post_reset", 2'd1, 2'd0, 2'd0, 1'b0, 0, 0);
    test_timeout();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_control_unit.md
Name: core_control_unit

Overview:
- Multi-cycle sequencer for the RV32I core.
- Drives PC, IR, MDR and register-file write strobes from the decode_unit control fields: fault, wb_op, jmp_op, mem_op.
- Arbitrates the single shared memory port between instruction fetch and load/store.
- Counts retired instructions and traps on illegal instructions or memory timeout.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready; 0 disables the timeout.
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- run  in  1  permits a new fetch to start
- dec_fault  in  1  decode_unit fault
- dec_wb_op  in  2  decode_unit wb_op (0 none, 1 result, 2 addr_alu)
- dec_jmp_op  in  2  decode_unit jmp_op (0 none, 1 unconditional, 2 conditional)
- dec_mem_op  in  2  decode_unit mem_op (0 none, 1 load, 2 store)
- br_taken  in  1  branch comparator result, valid in WB
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr_sel  out  1  address source: 0 = PC, 1 = addr_alu result
- ir_we  out  1  capture instruction
- mdr_we  out  1  capture load data
- rf_we  out  1  register-file write
- wb_sel  out  2  write-back source (equals dec_wb_op)
- pc_we  out  1  PC update
- pc_sel  out  1  next PC: 0 = PC+4, 1 = addr_alu result
- halted  out  1  trapped
- trap_cause  out  2  0 none, 1 illegal instruction, 2 memory timeout
- retired  out  RET_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async, rst_n=0):
  - State goes to IDLE immediately; all strobes 0; retired=0; trap_cause=0; halted=0; wait counter 0.
  - Reset mid-transaction drops mem_req at once; an in-flight mem_ready is then ignored.
- Outputs are Moore from state, except ir_we and mdr_we, which equal (state match & mem_ready).
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1 in the same cycle, go to DECODE.
- DECODE: one cycle. If dec_fault=1, go to TRAP with trap_cause=1; otherwise go to EXEC.
- EXEC: one cycle. If dec_mem_op!=0 go to MEM, else go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(dec_mem_op==2).
  - On mem_ready: mdr_we=(dec_mem_op==1), go to WB.
- WB: one cycle.
  - rf_we=(dec_wb_op!=0); wb_sel=dec_wb_op; pc_we=1.
  - pc_sel=1 iff dec_jmp_op==1, or dec_jmp_op==2 & br_taken.
  - retired increments, wrapping at 2^RET_W.
  - Next state: FETCH if run=1, else IDLE.
- Memory handshake:
  - mem_req is held until the cycle mem_ready=1; that cycle completes the transfer. mem_req is 0 the following cycle.
  - mem_ready while mem_req=0 is ignored.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_req=1 & mem_ready=0.
  - Counter reaching MEM_TIMEOUT with no ready: go to TRAP, trap_cause=2.
  - mem_ready in the cycle the count reaches MEM_TIMEOUT counts as success.
- TRAP: sticky. halted=1, all strobes 0, trap_cause held; left only via rst_n.
- dec_* inputs are valid only from DECODE through WB; they are ignored in all other states.
- Latency:
  - ALU instruction with zero-wait memory: FETCH → DECODE → EXEC → WB = 4 cycles.
  - Load or store: 5 cycles.

Decomposition:
- Shared header control_defs.vh holds: state encodings; WB_NONE/WB_RES/WB_ADDR; JMP_NONE/JMP_UNCOND/JMP_COND; MEM_NONE/MEM_LOAD/MEM_STORE; TRAP_* codes. decode_unit uses the same constants.
- One sub-module, mem_wait_timer: clear/enable inputs, expired output, parameter MEM_TIMEOUT.

Test Plan:
- ADDI (dec_wb_op=1, dec_jmp_op=0, dec_mem_op=0), mem_ready always 1, run=1 → ir_we at cycle 1, rf_we=1 & pc_we=1 & pc_sel=0 at cycle 4, retired=1.
- LW (dec_mem_op=1, dec_wb_op=1), mem_ready delayed 3 cycles in MEM → mem_req=1, mem_addr_sel=1, mem_we=0 for 4 cycles; mdr_we pulses once; rf_we in WB.
- SW (dec_mem_op=2, dec_wb_op=0) → mem_we=1 in MEM; rf_we=0 in WB; pc_sel=0.
- BNE (dec_jmp_op=2): br_taken=1 → pc_sel=1; br_taken=0 → pc_sel=0. JAL (dec_jmp_op=1) → pc_sel=1, rf_we=1.
- Zero instruction (dec_fault=1) → TRAP with trap_cause=1, halted=1; strobes stay 0 for 10 cycles; rst_n pulse → IDLE, retired=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → TRAP with trap_cause=2 after 4 wait cycles. Separately, rst_n dropped mid-FETCH → mem_req=0 immediately.
